// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS sine generator:
//   - default width constants
//   - quadrant enum used by the quarter-wave mirroring logic
//   - lut_value(): constant function that computes the quarter-wave ROM
//     contents at elaboration time
// Optional build macro used by the top: DDS_SINE_UNSIGNED_OUT_EN.
// ---------------------------------------------------------------------------
package dds_pkg;

    localparam int DDS_PHASE_W     = 24;
    localparam int DDS_SPEED_W     = 8;
    localparam int DDS_SPEED_SHIFT = 0;
    localparam int DDS_LUT_AW      = 6;
    localparam int DDS_OUT_W       = 8;

    localparam real DDS_PI = 3.14159265358979323846;

    // Upper two phase bits select the quadrant of the sine period.
    typedef enum logic [1:0] {
        Q0 = 2'd0,  // rising, positive
        Q1 = 2'd1,  // falling, positive (mirrored address)
        Q2 = 2'd2,  // falling, negative
        Q3 = 2'd3   // rising, negative (mirrored address)
    } quadrant_e;

    // Quarter-wave sample k of a 2^aw entry table with amplitude
    // 2^(ow-1)-1. The half-step offset makes entry k and entry
    // 2^aw-1-k exact mirror images, so no quadrant ever lands on zero
    // and the mirrored addresses line up without a correction term.
    function automatic int lut_value(input int k, input int aw, input int ow);
        real amp;
        real x;
        amp = (2.0 ** (ow - 1)) - 1.0;
        x   = amp * $sin(DDS_PI / 2.0 * (real'(k) + 0.5) / (2.0 ** aw));
        return $rtoi(x + 0.5);
    endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// ---------------------------------------------------------------------------
// dds_quarter_lut
// Registered quarter-wave sine ROM: 2^LUT_AW entries of OUT_W-1 bit
// unsigned magnitude, one cycle read latency. Contents are generated at
// elaboration time by dds_pkg::lut_value().
// Ports:
//   clk_i   system clock
//   addr_i  ROM address (quarter-wave position)
//   data_o  registered magnitude, valid one cycle after addr_i
// ---------------------------------------------------------------------------
module dds_quarter_lut
    import dds_pkg::*;
#(
    parameter int LUT_AW = DDS_LUT_AW,
    parameter int OUT_W  = DDS_OUT_W
) (
    input  logic                clk_i,
    input  logic [LUT_AW-1:0]   addr_i,
    output logic [OUT_W-2:0]    data_o
);

    localparam int DEPTH = 2 ** LUT_AW;

    logic [OUT_W-2:0] rom [DEPTH];
    logic [OUT_W-2:0] data_d;
    logic [OUT_W-2:0] data_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam int VAL = lut_value(gi, LUT_AW, OUT_W);
        assign rom[gi] = VAL[OUT_W-2:0];
    end

    always_comb begin
        data_d = rom[addr_i];
    end

    // No reset on the read register so the ROM can map onto block RAM;
    // downstream logic only consumes it under a valid qualifier.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_sine_gen.sv
// ---------------------------------------------------------------------------
// dds_sine_gen
// Direct-digital-synthesis sine source. A phase accumulator advances by
// (speed_i << SPEED_SHIFT) on every en_i tick; the upper phase bits drive a
// quarter-wave ROM with quadrant mirroring and a sign stage.
// Latency from the accumulator update (E0) to valid_o is 2 cycles; fully
// pipelined, one sample per en_i cycle.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   en_i     sample tick, one phase step per high cycle
//   speed_i  unsigned phase increment
//   sync_i   phase restart (accumulator cleared, wins over en_i)
//   sine_o   sine sample (two's complement, or offset-binary, see below)
//   valid_o  one-cycle strobe, sine_o updated this cycle
//   phase_o  current accumulator value
// Build option:
//   DDS_SINE_UNSIGNED_OUT_EN  when defined, sine_o is offset-binary
//                             (signed + 2^(OUT_W-1)), reset value 0x80.
// ---------------------------------------------------------------------------
module dds_sine_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W     = DDS_PHASE_W,
    parameter int SPEED_W     = DDS_SPEED_W,
    parameter int SPEED_SHIFT = DDS_SPEED_SHIFT,
    parameter int LUT_AW      = DDS_LUT_AW,
    parameter int OUT_W       = DDS_OUT_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [SPEED_W-1:0]  speed_i,
    input  logic                sync_i,
    output logic [OUT_W-1:0]    sine_o,
    output logic                valid_o,
    output logic [PHASE_W-1:0]  phase_o
);

`ifdef DDS_SINE_UNSIGNED_OUT_EN
    localparam logic [OUT_W-1:0] SINE_RST = {1'b1, {(OUT_W-1){1'b0}}};
`else
    localparam logic [OUT_W-1:0] SINE_RST = '0;
`endif

    // ---------------- stage E0: phase accumulator ----------------
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-1:0] acc_d, acc_q;
    logic               s0_valid_d, s0_valid_q;

    assign inc = {{(PHASE_W-SPEED_W){1'b0}}, speed_i} << SPEED_SHIFT;

    always_comb begin
        acc_d = acc_q;
        if (sync_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + inc;   // modular wrap is intended
        end
        s0_valid_d = en_i;
    end

    // ---------------- decode of the updated accumulator ----------------
    quadrant_e         quad;
    logic [LUT_AW-1:0] phase_addr;
    logic [LUT_AW-1:0] lut_addr;
    logic              neg;

    assign quad       = quadrant_e'(acc_q[PHASE_W-1 -: 2]);
    assign phase_addr = acc_q[PHASE_W-3 -: LUT_AW];

    always_comb begin
        lut_addr = phase_addr;
        neg      = 1'b0;
        unique case (quad)
            Q0: begin lut_addr = phase_addr;  neg = 1'b0; end
            Q1: begin lut_addr = ~phase_addr; neg = 1'b0; end
            Q2: begin lut_addr = phase_addr;  neg = 1'b1; end
            Q3: begin lut_addr = ~phase_addr; neg = 1'b1; end
            default: begin lut_addr = phase_addr; neg = 1'b0; end
        endcase
    end

    // ---------------- stage E1: ROM read and sign ----------------
    logic [OUT_W-2:0] lut_mag;
    logic             neg_d, neg_q;
    logic             s1_valid_d, s1_valid_q;

    dds_quarter_lut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_lut (
        .clk_i  (clk_i),
        .addr_i (lut_addr),
        .data_o (lut_mag)
    );

    always_comb begin
        neg_d      = neg;
        s1_valid_d = s0_valid_q;
    end

    // ---------------- stage E2: signed output ----------------
    logic [OUT_W-1:0] mag_ext;
    logic [OUT_W-1:0] signed_val;
    logic [OUT_W-1:0] sine_d, sine_q;
    logic             valid_d, valid_q;

    assign mag_ext = {1'b0, lut_mag};

    always_comb begin
        // Magnitude never exceeds 2^(OUT_W-1)-1, so negation cannot overflow.
        signed_val = neg_q ? (~mag_ext + 1'b1) : mag_ext;
        sine_d     = sine_q;
        if (s1_valid_q) begin
`ifdef DDS_SINE_UNSIGNED_OUT_EN
            sine_d = signed_val ^ {1'b1, {(OUT_W-1){1'b0}}};
`else
            sine_d = signed_val;
`endif
        end
        valid_d = s1_valid_q;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            s0_valid_q <= 1'b0;
            neg_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            sine_q     <= SINE_RST;
            valid_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            s0_valid_q <= s0_valid_d;
            neg_q      <= neg_d;
            s1_valid_q <= s1_valid_d;
            sine_q     <= sine_d;
            valid_q    <= valid_d;
        end
    end

    assign sine_o  = sine_q;
    assign valid_o = valid_q;
    assign phase_o = acc_q;

endmodule

// File: tb/tb_dds_sine_gen.sv
// ---------------------------------------------------------------------------
// tb_dds_sine_gen
// Self-checking bench for dds_sine_gen (SPEED_SHIFT=16). A behavioural model
// computes the expected phase and the sine sample directly from
// sin(2*pi*(p+0.5)/256) and schedules each sample two cycles after its tick;
// a compare process checks phase_o, valid_o and sine_o on every falling edge.
// Literal checks pin the model at the key points of the period.
// ---------------------------------------------------------------------------
module tb_dds_sine_gen;

    localparam int  PHASE_W = 24;
    localparam int  SHIFT   = 16;
    localparam real PI      = 3.14159265358979323846;
`ifdef DDS_SINE_UNSIGNED_OUT_EN
    localparam int  OFS = 128;
`else
    localparam int  OFS = 0;
`endif
    localparam logic [7:0] SINE_RST = 8'(OFS);

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               en_i = 1'b0;
    logic [7:0]         speed_i = 8'd0;
    logic               sync_i = 1'b0;
    logic [7:0]         sine_o;
    logic               valid_o;
    logic [PHASE_W-1:0] phase_o;

    dds_sine_gen #(
        .PHASE_W     (PHASE_W),
        .SPEED_W     (8),
        .SPEED_SHIFT (SHIFT),
        .LUT_AW      (6),
        .OUT_W       (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (en_i),
        .speed_i (speed_i),
        .sync_i  (sync_i),
        .sine_o  (sine_o),
        .valid_o (valid_o),
        .phase_o (phase_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected sample for a phase: full-period sine at 256 points per period
    // with a half-step offset, rounded half away from zero.
    function automatic logic [7:0] model_sine(input logic [PHASE_W-1:0] ph);
        real x;
        int  v;
        x = 127.0 * $sin(2.0 * PI * (real'(ph >> (PHASE_W - 8)) + 0.5) / 256.0);
        v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
        v = v + OFS;
        return v[7:0];
    endfunction

    // ---------------- model ----------------
    typedef struct {
        int         due;
        logic [7:0] val;
    } exp_t;

    exp_t               sb[$];
    int                 cyc = 0;
    logic [PHASE_W-1:0] m_acc = '0;
    logic [7:0]         exp_sine = SINE_RST;

    always @(posedge clk_i) begin
        cyc++;
        if (rst_ni) begin
            if (sync_i)
                m_acc = '0;
            else if (en_i)
                m_acc = m_acc + (PHASE_W'(speed_i) << SHIFT);
            if (en_i)
                sb.push_back('{cyc + 2, model_sine(m_acc)});
        end
    end

    always @(negedge rst_ni) begin
        sb.delete();
        m_acc    = '0;
        exp_sine = SINE_RST;
    end

    // ---------------- compare process ----------------
    always @(negedge clk_i) begin : cmp
        logic exp_v;
        exp_t e;
        exp_v = 1'b0;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            exp_v    = 1'b1;
            exp_sine = e.val;
        end
        chk("valid_o", 32'(valid_o), 32'(exp_v));
        chk("sine_o", 32'(sine_o), 32'(exp_sine));
        chk("phase_o", 32'(phase_o), 32'(m_acc));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic en, input logic sy, input logic [7:0] spd);
        en_i    = en;
        sync_i  = sy;
        speed_i = spd;
        @(negedge clk_i);
    endtask

    initial begin
        int first;
        int cnt;
        logic [7:0] speeds [8];

        // Reset held for 5 cycles with en_i toggling.
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) tick(1'(i % 2), 1'b0, 8'd1);
        rst_ni = 1'b1;
        tick(1'b0, 1'b0, 8'd0);

        // Period walk: speed 1, one tick every 4 cycles.
        for (int k = 1; k <= 256; k++) begin
            tick(1'b1, 1'b0, 8'd1);
            tick(1'b0, 1'b0, 8'd1);
            tick(1'b0, 1'b0, 8'd1);
            tick(1'b0, 1'b0, 8'd1);
            case (k)
                1:   begin chk("walk_k1", 32'(sine_o), 32'(8'd5 + 8'(OFS)));
                           chk("model_k1", 32'(model_sine(24'h010000)), 32'(8'd5 + 8'(OFS))); end
                63:  chk("walk_k63", 32'(sine_o), 32'(8'd127 + 8'(OFS)));
                64:  begin chk("walk_k64", 32'(sine_o), 32'(8'd127 + 8'(OFS)));
                           chk("model_k64", 32'(model_sine(24'h400000)), 32'(8'd127 + 8'(OFS))); end
                128: begin chk("walk_k128", 32'(sine_o), 32'(8'hFE + 8'(OFS)));
                           chk("model_k128", 32'(model_sine(24'h800000)), 32'(8'hFE + 8'(OFS))); end
                192: begin chk("walk_k192", 32'(sine_o), 32'(8'h81 + 8'(OFS)));
                           chk("model_k192", 32'(model_sine(24'hC00000)), 32'(8'h81 + 8'(OFS))); end
                256: begin chk("walk_k256", 32'(sine_o), 32'(8'd2 + 8'(OFS)));
                           chk("walk_wrap_phase", 32'(phase_o), 32'd0); end
                default: ;
            endcase
        end

        // Latency / throughput: 10 back-to-back ticks.
        first = -1;
        cnt   = 0;
        for (int i = 0; i < 14; i++) begin
            tick(i < 10, 1'b0, 8'd3);
            if (valid_o) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
        chk("burst_first_valid", 32'(first), 32'd2);
        chk("burst_valid_count", 32'(cnt), 32'd10);

        // Assorted speeds, including hold (speed 0) and wrap-heavy steps.
        speeds = '{8'hFF, 8'h00, 8'h00, 8'h80, 8'h37, 8'hC1, 8'h40, 8'h01};
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, speeds[i]);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'd0);

        // Sync priority.
        tick(1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'd1);
        chk("sync_pre_phase", 32'(phase_o), 32'h050000);
        tick(1'b1, 1'b1, 8'd1);
        chk("sync_phase", 32'(phase_o), 32'd0);
        tick(1'b0, 1'b0, 8'd1);
        tick(1'b0, 1'b0, 8'd1);
        chk("sync_valid", 32'(valid_o), 32'd1);
        chk("sync_sample", 32'(sine_o), 32'(8'd2 + 8'(OFS)));
        tick(1'b1, 1'b0, 8'd1);
        chk("sync_next_phase", 32'(phase_o), 32'h010000);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'd0);

        // Reset mid-pipeline.
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 8'd5);
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_sine", 32'(sine_o), 32'(SINE_RST));
        chk("midrst_phase", 32'(phase_o), 32'd0);
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) tick(1'(i % 2), 1'b0, 8'd5);
        tick(1'b0, 1'b0, 8'd5);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'd5);
        tick(1'b1, 1'b0, 8'd5);
        tick(1'b0, 1'b0, 8'd5);
        chk("postrst_no_early_valid", 32'(valid_o), 32'd0);
        tick(1'b0, 1'b0, 8'd5);
        chk("postrst_valid", 32'(valid_o), 32'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
